// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
// Groups the request side (in_*, op_sel, register fields, imm) and the
// response side (out_*, instr, err, enc_count) of the LEGv8 instruction
// encoder into one bundle.
//   master : the agent that issues encode requests and consumes words
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if;
  // request channel
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [25:0] imm;
  // response channel
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  // status
  logic        err;
  logic [15:0] enc_count;

  modport master (
    output in_valid, op_sel, rd, rn, rm, imm, out_ready,
    input  in_ready, out_valid, instr, err, enc_count
  );

  modport slave (
    input  in_valid, op_sel, rd, rn, rm, imm, out_ready,
    output in_ready, out_valid, instr, err, enc_count
  );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Encodes ADD/SUB/AND/ORR (R-type), LDUR/STUR (D-type), CBZ (CB-type) and
// B (B-type) requests into 32-bit LEGv8 words and queues them in a 4-entry
// FIFO toward a ready/valid consumer.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : instr_encoder_if.slave
//          in_valid/in_ready  request handshake
//          op_sel, rd, rn, rm, imm  request fields
//          out_valid/out_ready/instr  response handshake, head of FIFO
//          err        one-cycle pulse after accepting an invalid op_sel
//          enc_count  valid words encoded since reset (wraps)
// ----------------------------------------------------------------------------
module instr_encoder (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [5:0]  OPC_B    = 6'h05;

  localparam logic [2:0]  DEPTH    = 3'd4;

  // FIFO storage and bookkeeping
  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_err;
  logic [15:0] r_enc_count;

  // combinational helpers
  logic [31:0] w_word;
  logic        w_op_ok;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_not_empty;

  // --------------------------------------------------------------------------
  // Encoder: pure function of the request fields
  // --------------------------------------------------------------------------
  always_comb begin
    w_word  = 32'h0;
    w_op_ok = 1'b1;
    case (bus.op_sel)
      4'd0: w_word = {OPC_ADD, bus.rm, 6'b0, bus.rn, bus.rd};
      4'd1: w_word = {OPC_SUB, bus.rm, 6'b0, bus.rn, bus.rd};
      4'd2: w_word = {OPC_AND, bus.rm, 6'b0, bus.rn, bus.rd};
      4'd3: w_word = {OPC_ORR, bus.rm, 6'b0, bus.rn, bus.rd};
      4'd4: w_word = {OPC_LDUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
      4'd5: w_word = {OPC_STUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
      4'd6: w_word = {OPC_CBZ, bus.imm[18:0], bus.rd};
      4'd7: w_word = {OPC_B, bus.imm[25:0]};
      default: begin
        w_word  = 32'h0;
        w_op_ok = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshakes. in_ready depends only on the occupancy register, so a pop at
  // full does not open the input in the same cycle.
  // --------------------------------------------------------------------------
  assign w_not_empty   = (r_count != 3'd0);
  assign bus.in_ready  = (r_count != DEPTH);
  assign w_accept      = bus.in_valid & bus.in_ready;
  // invalid opcodes complete the handshake but never reach the FIFO
  assign w_push        = w_accept & w_op_ok;
  assign w_pop         = w_not_empty & bus.out_ready;

  // --------------------------------------------------------------------------
  // Pointer / occupancy / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_err       <= 1'b0;
      r_enc_count <= 16'd0;
    end else begin
      // 2-bit pointers wrap 3 -> 0 naturally
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;   // idle, or push+pop cancel out
      endcase

      r_err <= w_accept & ~w_op_ok;

      if (w_push) r_enc_count <= r_enc_count + 16'd1;
    end
  end

  // Storage has no reset; stale contents are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // --------------------------------------------------------------------------
  // Outputs. instr is forced to zero when empty so reset shows a clean word;
  // while non-empty the head only changes on a pop, so it is stable under
  // backpressure.
  // --------------------------------------------------------------------------
  assign bus.out_valid = w_not_empty;
  assign bus.instr     = w_not_empty ? r_mem[r_rd_ptr] : 32'h0;
  assign bus.err       = r_err;
  assign bus.enc_count = r_enc_count;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
// Directed scenarios for the documented examples followed by a randomized
// run, all checked against a queue-based reference model of the encoder.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_q [$];
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_err = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word built from the field layout with plain arithmetic.
  function automatic logic [31:0] ref_word(input int op, input int rd, input int rn,
                                           input int rm, input int imm);
    longint w;
    case (op)
      0: w = (longint'('h458) << 21) + (rm << 16) + (rn << 5) + rd;
      1: w = (longint'('h658) << 21) + (rm << 16) + (rn << 5) + rd;
      2: w = (longint'('h450) << 21) + (rm << 16) + (rn << 5) + rd;
      3: w = (longint'('h550) << 21) + (rm << 16) + (rn << 5) + rd;
      4: w = (longint'('h7C2) << 21) + ((imm % 512) << 12) + (rn << 5) + rd;
      5: w = (longint'('h7C0) << 21) + ((imm % 512) << 12) + (rn << 5) + rd;
      6: w = (longint'('hB4) << 24) + (longint'(imm % 524288) << 5) + rd;
      default: w = (longint'('h05) << 26) + imm;
    endcase
    return 32'(w);
  endfunction

  task automatic drive(input logic v, input int op, input int rd, input int rn,
                       input int rm, input int imm, input logic ordy);
    bus.in_valid  = v;
    bus.op_sel    = 4'(op);
    bus.rd        = 5'(rd);
    bus.rn        = 5'(rn);
    bus.rm        = 5'(rm);
    bus.imm       = 26'(imm);
    bus.out_ready = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 0, 0, 0, 0, 0, ordy);
  endtask

  // One clock: compare outputs to the model at the falling edge, then
  // advance the model across the rising edge. Returns at posedge + 1.
  task automatic step();
    bit acc;
    bit pop;
    int op;
    logic [31:0] w;
    @(negedge clk);
    chk_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk_eq("instr", bus.instr, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk_eq("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 4));
    chk_eq("err", 32'(bus.err), 32'(exp_err));
    chk_eq("enc_count", 32'(bus.enc_count), 32'(exp_cnt));
    acc = bus.in_valid && (exp_q.size() < 4);
    pop = bus.out_ready && (exp_q.size() != 0);
    op  = int'(bus.op_sel);
    w   = ref_word(op, int'(bus.rd), int'(bus.rn), int'(bus.rm), int'(bus.imm));
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = 16'd0;
      exp_err = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      exp_err = acc && (op > 7);
      if (acc && op <= 7) begin
        exp_q.push_back(w);
        exp_cnt = exp_cnt + 16'd1;
        $display("txn op=%0d word=%h depth=%0d", op, w, exp_q.size());
      end else if (acc) begin
        $display("txn op=%0d rejected", op);
      end
    end
    #1;
  endtask

  initial begin
    logic [15:0] cnt_before;

    // ---------------- reset ----------------
    rst = 1'b1;
    idle(1'b0);
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // ---------------- documented encodings ----------------
    drive(1'b1, 0, 3, 1, 2, 0, 1'b0);        // ADD
    step();
    chk_eq("add_word", bus.instr, 32'h8B020023);
    chk_eq("add_latency", 32'(bus.out_valid), 32'd1);
    drive(1'b1, 1, 3, 1, 2, 0, 1'b1);        // SUB, pops ADD
    step();
    chk_eq("sub_word", bus.instr, 32'hCB020023);
    drive(1'b1, 4, 2, 1, 0, 8, 1'b1);        // LDUR
    step();
    chk_eq("ldur_word", bus.instr, 32'hF8408022);
    drive(1'b1, 6, 5, 0, 0, 3, 1'b1);        // CBZ
    step();
    chk_eq("cbz_word", bus.instr, 32'hB4000065);
    drive(1'b1, 7, 0, 0, 0, 'h10, 1'b1);     // B
    step();
    chk_eq("b_word", bus.instr, 32'h14000010);
    idle(1'b1);
    repeat (2) step();

    // ---------------- invalid op ----------------
    cnt_before = bus.enc_count;
    drive(1'b1, 9, 1, 1, 1, 0, 1'b0);
    step();
    chk_eq("inv_err", 32'(bus.err), 32'd1);
    chk_eq("inv_no_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("inv_cnt", 32'(bus.enc_count), 32'(cnt_before));
    drive(1'b1, 0, 3, 1, 2, 0, 1'b0);
    step();
    chk_eq("inv_err_pulse", 32'(bus.err), 32'd0);
    chk_eq("inv_then_add", bus.instr, 32'h8B020023);
    idle(1'b1);
    repeat (2) step();

    // ---------------- fill to full, backpressure ----------------
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 0, k + 10, 1, 2, 0, 1'b0);
      step();
    end
    chk_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;                     // fifth request still presented
    step();
    chk_eq("pop_full_ready", 32'(bus.in_ready), 32'd1);
    step();
    idle(1'b1);
    repeat (6) step();

    // ---------------- steady push+pop at depth 2 ----------------
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2, k, k + 1, k + 2, 0, 1'b0);
      step();
    end
    cnt_before = bus.enc_count;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3, k + 20, k, 31 - k, 0, 1'b1);
      step();
      chk_eq("pp_depth_ready", 32'(bus.in_ready), 32'd1);
    end
    chk_eq("pp_cnt", 32'(bus.enc_count), 32'(cnt_before + 16'd6));
    idle(1'b1);
    repeat (3) step();

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5, k, k, 0, k * 7, 1'b0);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 0, 3, 1, 2, 0, 1'b0);
    step();
    rst = 1'b0;
    idle(1'b0);
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_instr", bus.instr, 32'h0);
    chk_eq("rst_cnt", 32'(bus.enc_count), 32'd0);
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 600; n++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                        : int'($urandom_range(0, 7));
      drive(($urandom_range(0, 9) < 7), op, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 26'h3FFFFFF)), ($urandom_range(0, 9) < 5));
      step();
    end
    idle(1'b1);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have these ports, each given as name, direction, width and meaning:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  encode request present.
- in_ready  output  1  request accepted when in_valid & in_ready at the clk edge.
- op_sel  input  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 B; 8-15 are invalid.
- rd  input  5  Rd/Rt field.
- rn  input  5  Rn field.
- rm  input  5  Rm field.
- imm  input  26  immediate/offset; only the low bits relevant to the format are used.
- out_valid  output  1  instr holds a valid word.
- out_ready  input  1  downstream accepts instr.
- instr  output  32  encoded LEGv8 instruction word.
- err  output  1  one-cycle pulse on acceptance of an invalid op_sel.
- enc_count  output  16  number of valid words encoded since reset.

Function
REQ-003 SHALL encode R-type (ADD/SUB/AND/ORR) as opcode[31:21], rm[20:16], 6'b0[15:10], rn[9:5], rd[4:0].
- Opcodes: ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550.
REQ-004 SHALL encode D-type as opcode[31:21], imm[8:0] at [20:12], 2'b00 at [11:10], rn[9:5], rd[4:0].
- Opcodes: LDUR 11'h7C2, STUR 11'h7C0.
REQ-005 SHALL encode CBZ as 8'hB4 at [31:24], imm[18:0] at [23:5], rd[4:0].
REQ-006 SHALL encode B as 6'h05 at [31:26], imm[25:0] at [25:0].
REQ-007 SHALL buffer encoded words in a 4-entry FIFO with 2-bit read/write pointers that wrap from 3 to 0, plus a 3-bit occupancy count.
REQ-008 SHALL drive in_ready = (occupancy < 4), from registered state only; no combinational path from out_ready.
REQ-009 SHALL, on an accepted valid request, write the word at the clk edge.
- out_valid SHALL be high in the following cycle when the FIFO was empty (latency 1 cycle).
REQ-010 SHALL drive out_valid = (occupancy != 0), with instr = the head entry.
- instr SHALL be held stable while out_valid & !out_ready.
REQ-011 SHALL pop the head when out_valid & out_ready at the clk edge.
REQ-012 SHALL handle a simultaneous push and pop by leaving occupancy unchanged and advancing both pointers.
REQ-013 SHALL handle a pop at full with in_valid high as follows:
- in_ready is low that cycle, so there is no push.
- in_ready rises in the next cycle.
REQ-014 SHALL handle an invalid op_sel as follows:
- The request is accepted (subject to in_ready) and not written to the FIFO.
- err is high for exactly the next cycle.
- enc_count does not change.
REQ-015 SHALL increment enc_count by 1 per accepted valid request, wrapping from 16'hFFFF to 0.
REQ-016 SHALL treat in_valid low, or in_ready low, as no operation: no state change and no err.

Reset
REQ-017 SHALL, while rst is high at a clk edge, set occupancy, pointers, enc_count and err to 0 and hold in_ready at 1.
- out_valid SHALL be 0 and instr 32'h0.
REQ-018 SHALL, on rst asserted mid-operation, discard all buffered words and ignore requests presented in that cycle.
REQ-019 SHALL accept requests from the first edge after rst deasserts.

Verification
REQ-020 ADD rd=3 rn=1 rm=2 -> instr=32'h8B020023 with out_valid one cycle later; SUB with the same fields -> 32'hCB020023.
REQ-021 LDUR rd=2 rn=1 imm=8 -> 32'hF8408022; CBZ rd=5 imm=3 -> 32'hB4000065; B imm=26'h10 -> 32'h14000010.
REQ-022 Five back-to-back requests with out_ready=0:
- Words 1-4 are accepted, then in_ready=0 and the fifth is held.
- Raising out_ready yields the words in order and the fifth is accepted next cycle.
REQ-023 op_sel=9 with in_valid -> err=1 for one cycle, no out_valid, enc_count unchanged.
- A following ADD encodes normally.
REQ-024 FIFO at 2 entries with simultaneous push and pop for 6 cycles -> occupancy stays 2, order preserved across pointer wrap, enc_count +6.
REQ-025 rst asserted with 3 entries buffered -> next cycle out_valid=0, instr=0, enc_count=0, in_ready=1.
